fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage and IF/ID pipeline register of the pipelined CPU. It owns the PC, issues one word-addressed request at a time to instruction memory, and captures the returned instruction into the IF/ID register consumed by the decode/control stage. It honours a stall from the hazard logic and a redirect (taken branch, J, JM target) from the PC-select logic, squashing wrong-path fetches.

## Interface
- PC_W, 32, PC and address width (word addressed)
- INSTR_W, 32, instruction width; opcode is bits [INSTR_W-1 -: 4]
- RESET_PC, 0, first fetch address after reset

- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- imem_req  out  1  request valid
- imem_addr  out  PC_W  request address
- imem_ready  in  1  memory accepts request this cycle (req && ready)
- imem_rvalid  in  1  response data valid; earliest the cycle after acceptance
- imem_rdata  in  INSTR_W  response instruction
- stall  in  1  hold IF/ID contents
- redirect  in  1  PC must change to redirect_pc
- redirect_pc  in  PC_W  new fetch address
- if_id_valid  out  1  IF/ID holds a real instruction
- if_id_instr  out  INSTR_W  instruction; all-zero (NOP) when invalid
- if_id_opcode  out  4  top 4 bits of if_id_instr
- if_id_pc  out  PC_W  address of if_id_instr
- if_id_pc1  out  PC_W  if_id_pc + 1, wraps modulo 2^PC_W

## Operation
- One outstanding request max. Memory permits imem_addr to change while imem_req is high and not yet accepted.
- States: IDLE, REQ, WAIT, HOLD. Flag drop marks the in-flight response as wrong-path.
- IDLE: entered only on reset; next cycle -> REQ.
- REQ: imem_req=1, imem_addr=pc. On ready -> WAIT.
- WAIT: on rvalid with drop=1: discard, clear drop -> REQ. On rvalid with drop=0 and !stall: load IF/ID {valid=1, rdata, pc, pc+1}, pc<=pc+1 -> REQ. On rvalid with stall: capture rdata in skid buffer, pc<=pc+1 -> HOLD.
- HOLD: when !stall, load IF/ID from buffer -> REQ.
- Redirect (highest priority, any state but IDLE): pc<=redirect_pc; IF/ID valid<=0, instr<=NOP even if stall is high. REQ with ready same cycle -> WAIT with drop=1. REQ without ready -> stays REQ at new address. WAIT -> drop<=1 (or, if rvalid that cycle, discard and -> REQ). HOLD -> buffer discarded -> REQ.
- IF/ID update without redirect: stall=1 holds all fields. stall=0 with no instruction delivered loads a bubble (valid=0, instr=0, opcode=0); pc fields hold.

## Timing
- Reset values: state IDLE, pc=RESET_PC, drop=0, imem_req=0, imem_addr=RESET_PC, if_id_valid=0, if_id_instr=0, if_id_opcode=0, if_id_pc=0, if_id_pc1=0.
- All outputs registered or decoded from state/pc only; no combinational path from inputs to outputs.
- Best case: request accepted cycle N, rvalid N+1, IF/ID valid from N+2, next request issued N+2. Throughput 1 instruction / 2 cycles.
- Redirect asserted cycle N: first redirect-path request on imem_addr at N+1. No wrong-path instruction ever reaches if_id_valid=1.
- pc increment wraps from 2^PC_W-1 to 0. No overflow flag.
- Reset mid-transaction: outstanding response after reset is not expected; memory is reset by the same rst.

## Structure
- Shared package cpu_pkg: opcode constants (NOP 0000 … BRN 1011), INSTR_NOP = all-zero word, PC_W/INSTR_W defaults.
- One sub-module is natural: if_id_reg (valid/instr/pc/pc1 register with stall-hold and flush). FSM, pc and skid buffer stay in fetch_stage.

## Test plan
- Reset, memory always ready, 1-cycle latency, rdata=addr|0x40000000 -> requests at 0,1,2,…; IF/ID shows pc=0,pc1=1, opcode 0100, then pc=1 every 2 cycles.
- stall held 5 cycles while rvalid for addr 3 arrives -> IF/ID keeps addr 2 contents; addr 3 appears the cycle after stall drops; no request issued during HOLD.
- redirect to 0x20 in the cycle the addr-5 request is accepted -> addr-5 response dropped; next request 0x20; IF/ID never valid with pc=5.
- redirect with stall=1 and valid IF/ID -> if_id_valid=0, instr=0 next cycle.
- imem_ready low 4 cycles, redirect to 0x10 on cycle 2 -> imem_addr switches to 0x10; only 0x10 is fetched.
- RESET_PC=0xFFFFFFFF -> second request address is 0, if_id_pc1=0 for first instruction.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode encodings, default widths, fetch FSM states.
package cpu_pkg;

  localparam int PC_W_DEF    = 32;
  localparam int INSTR_W_DEF = 32;

  typedef enum logic [3:0] {
    OP_NOP = 4'b0000,
    OP_ADD = 4'b0001,
    OP_SUB = 4'b0010,
    OP_AND = 4'b0011,
    OP_OR  = 4'b0100,
    OP_XOR = 4'b0101,
    OP_LD  = 4'b0110,
    OP_ST  = 4'b0111,
    OP_LI  = 4'b1000,
    OP_J   = 4'b1001,
    OP_JM  = 4'b1010,
    OP_BRN = 4'b1011
  } opcode_e;

  localparam logic [INSTR_W_DEF-1:0] INSTR_NOP = '0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: load, stall-hold, bubble insertion and flush.
import cpu_pkg::*;

module if_id_reg #(
  parameter int PC_W    = PC_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               stall,
  input  logic               load,
  input  logic [INSTR_W-1:0] load_instr,
  input  logic [PC_W-1:0]    load_pc,
  output logic               valid,
  output logic [INSTR_W-1:0] instr,
  output logic [3:0]         opcode,
  output logic [PC_W-1:0]    pc,
  output logic [PC_W-1:0]    pc1
);

  // Flush beats stall; pc fields are left alone on flush and bubbles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      instr <= '0;
      pc    <= '0;
      pc1   <= '0;
    end else if (flush) begin
      valid <= 1'b0;
      instr <= '0;
    end else if (!stall) begin
      if (load) begin
        valid <= 1'b1;
        instr <= load_instr;
        pc    <= load_pc;
        pc1   <= load_pc + PC_W'(1);
      end else begin
        valid <= 1'b0;
        instr <= '0;
      end
    end
  end

  assign opcode = instr[INSTR_W-1 -: 4];

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, single-outstanding imem request FSM, skid buffer.
// state | meaning
// IDLE  | post-reset, no request yet
// REQ   | imem_req high at pc, waiting for imem_ready
// WAIT  | request accepted, waiting for imem_rvalid (drop = wrong-path)
// HOLD  | response parked in skid buffer while decode is stalled
import cpu_pkg::*;

module fetch_stage #(
  parameter int              PC_W     = PC_W_DEF,
  parameter int              INSTR_W  = INSTR_W_DEF,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ready,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               stall,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               if_id_valid,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [3:0]         if_id_opcode,
  output logic [PC_W-1:0]    if_id_pc,
  output logic [PC_W-1:0]    if_id_pc1
);

  fetch_state_e       state, state_next;
  logic [PC_W-1:0]    pc, pc_next;
  logic               drop, drop_next;
  logic [INSTR_W-1:0] skid_instr;
  logic [PC_W-1:0]    skid_pc;
  logic               skid_we;
  logic               ifid_load;
  logic               ifid_flush;
  logic [INSTR_W-1:0] ifid_instr;
  logic [PC_W-1:0]    ifid_pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      pc         <= RESET_PC;
      drop       <= 1'b0;
      skid_instr <= '0;
      skid_pc    <= '0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      drop  <= drop_next;
      if (skid_we) begin
        skid_instr <= imem_rdata;
        skid_pc    <= pc;
      end
    end
  end

  always_comb begin
    state_next = state;
    pc_next    = pc;
    drop_next  = drop;
    skid_we    = 1'b0;
    ifid_load  = 1'b0;
    ifid_flush = 1'b0;
    ifid_instr = imem_rdata;
    ifid_pc    = pc;
    case (state)
      ST_IDLE: state_next = ST_REQ;
      ST_REQ: begin
        if (redirect) begin
          pc_next    = redirect_pc;
          ifid_flush = 1'b1;
          if (imem_ready) begin
            state_next = ST_WAIT;
            drop_next  = 1'b1;
          end
        end else if (imem_ready) begin
          state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (redirect) begin
          pc_next    = redirect_pc;
          ifid_flush = 1'b1;
          // A response landing in the redirect cycle is stale; discard it now.
          if (imem_rvalid) begin
            state_next = ST_REQ;
            drop_next  = 1'b0;
          end else begin
            drop_next  = 1'b1;
          end
        end else if (imem_rvalid) begin
          if (drop) begin
            drop_next  = 1'b0;
            state_next = ST_REQ;
          end else if (!stall) begin
            ifid_load  = 1'b1;
            pc_next    = pc + PC_W'(1);
            state_next = ST_REQ;
          end else begin
            skid_we    = 1'b1;
            pc_next    = pc + PC_W'(1);
            state_next = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (redirect) begin
          pc_next    = redirect_pc;
          ifid_flush = 1'b1;
          state_next = ST_REQ;
        end else if (!stall) begin
          ifid_load  = 1'b1;
          ifid_instr = skid_instr;
          ifid_pc    = skid_pc;
          state_next = ST_REQ;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign imem_req  = (state == ST_REQ);
  assign imem_addr = pc;

  if_id_reg #(
    .PC_W    (PC_W),
    .INSTR_W (INSTR_W)
  ) u_if_id (
    .clk        (clk),
    .rst        (rst),
    .flush      (ifid_flush),
    .stall      (stall),
    .load       (ifid_load),
    .load_instr (ifid_instr),
    .load_pc    (ifid_pc),
    .valid      (if_id_valid),
    .instr      (if_id_instr),
    .opcode     (if_id_opcode),
    .pc         (if_id_pc),
    .pc1        (if_id_pc1)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: two instances (RESET_PC 0 and all-ones), 1-cycle memory models.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        ready = 1'b1;

  logic        req_a, rvalid_a, valid_a;
  logic [31:0] addr_a, rdata_a, instr_a, pc_a, pc1_a, acc_a;
  logic [3:0]  opc_a;

  logic        req_b, rvalid_b, valid_b;
  logic [31:0] addr_b, rdata_b, instr_b, pc_b, pc1_b;
  logic [3:0]  opc_b;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  fetch_stage #(.PC_W(32), .INSTR_W(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst),
    .imem_req(req_a), .imem_addr(addr_a), .imem_ready(ready),
    .imem_rvalid(rvalid_a), .imem_rdata(rdata_a),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .if_id_valid(valid_a), .if_id_instr(instr_a), .if_id_opcode(opc_a),
    .if_id_pc(pc_a), .if_id_pc1(pc1_a)
  );

  fetch_stage #(.PC_W(32), .INSTR_W(32), .RESET_PC(32'hFFFF_FFFF)) dut_wrap (
    .clk(clk), .rst(rst),
    .imem_req(req_b), .imem_addr(addr_b), .imem_ready(1'b1),
    .imem_rvalid(rvalid_b), .imem_rdata(rdata_b),
    .stall(1'b0), .redirect(1'b0), .redirect_pc(32'h0),
    .if_id_valid(valid_b), .if_id_instr(instr_b), .if_id_opcode(opc_b),
    .if_id_pc(pc_b), .if_id_pc1(pc1_b)
  );

  // Memory models: fixed one-cycle latency, rdata = addr | 0x4000_0000.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rvalid_a <= 1'b0;
      rdata_a  <= '0;
      acc_a    <= 32'hDEAD_BEEF;
      rvalid_b <= 1'b0;
      rdata_b  <= '0;
    end else begin
      rvalid_a <= req_a && ready;
      rdata_a  <= addr_a | 32'h4000_0000;
      if (req_a && ready) acc_a <= addr_a;
      rvalid_b <= req_b;
      rdata_b  <= addr_b | 32'h4000_0000;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    tick();
    tick();
    chk("rst_req",    req_a, 0);
    chk("rst_addr",   addr_a, 32'h0);
    chk("rst_valid",  valid_a, 0);
    chk("rst_instr",  instr_a, 32'h0);
    chk("rst_opcode", opc_a, 0);
    chk("rst_pc",     pc_a, 32'h0);
    chk("rst_pc1",    pc1_a, 32'h0);
    chk("rst_addr_w", addr_b, 32'hFFFF_FFFF);
    rst = 1'b0;

    tick(); // E1: IDLE -> REQ
    chk("e1_req",   req_a, 1);
    chk("e1_addr",  addr_a, 32'h0);
    chk("e1_req_w", req_b, 1);
    chk("e1_addr_w", addr_b, 32'hFFFF_FFFF);
    tick(); // E2: accepted
    chk("e2_req",    req_a, 0);
    chk("e2_valid",  valid_a, 0);
    tick(); // E3: first instruction in IF/ID
    chk("e3_valid",  valid_a, 1);
    chk("e3_pc",     pc_a, 32'h0);
    chk("e3_pc1",    pc1_a, 32'h1);
    chk("e3_opcode", opc_a, 4'b0100);
    chk("e3_instr",  instr_a, 32'h4000_0000);
    chk("e3_addr",   addr_a, 32'h1);
    chk("e3_req",    req_a, 1);
    chk("w_valid",   valid_b, 1);
    chk("w_pc",      pc_b, 32'hFFFF_FFFF);
    chk("w_pc1",     pc1_b, 32'h0);
    chk("w_addr",    addr_b, 32'h0);
    chk("w_req",     req_b, 1);
    tick(); // E4: bubble
    chk("e4_valid",  valid_a, 0);
    chk("e4_instr",  instr_a, 32'h0);
    tick(); // E5
    chk("e5_valid",  valid_a, 1);
    chk("e5_pc",     pc_a, 32'h1);
    chk("e5_pc1",    pc1_a, 32'h2);
    tick(); // E6
    tick(); // E7: addr 2 in IF/ID, request for 3 pending
    chk("e7_pc",     pc_a, 32'h2);
    chk("e7_addr",   addr_a, 32'h3);

    stall = 1'b1;
    tick(); // E8: addr 3 accepted, IF/ID held
    chk("s8_valid",  valid_a, 1);
    chk("s8_pc",     pc_a, 32'h2);
    for (int i = 9; i <= 12; i++) begin
      tick(); // E9..E12: response parked, no new request
      chk("hold_req",   req_a, 0);
      chk("hold_pc",    pc_a, 32'h2);
      chk("hold_instr", instr_a, 32'h4000_0002);
    end
    stall = 1'b0;
    tick(); // E13: skid buffer released
    chk("r13_valid", valid_a, 1);
    chk("r13_pc",    pc_a, 32'h3);
    chk("r13_pc1",   pc1_a, 32'h4);
    chk("r13_instr", instr_a, 32'h4000_0003);
    chk("r13_req",   req_a, 1);
    chk("r13_addr",  addr_a, 32'h4);
    tick(); // E14
    tick(); // E15: request for 5 pending
    chk("e15_pc",    pc_a, 32'h4);
    chk("e15_addr",  addr_a, 32'h5);

    redirect = 1'b1;
    redirect_pc = 32'h20;
    tick(); // E16: accept + redirect -> WAIT with drop
    redirect = 1'b0;
    chk("rd16_req",    req_a, 0);
    chk("rd16_addr",   addr_a, 32'h20);
    chk("rd16_valid",  valid_a, 0);
    chk("rd16_rvalid", rvalid_a, 1);
    tick(); // E17: addr-5 response dropped
    chk("rd17_valid",  valid_a, 0);
    chk("rd17_req",    req_a, 1);
    chk("rd17_addr",   addr_a, 32'h20);
    tick(); // E18
    chk("rd18_valid",  valid_a, 0);
    tick(); // E19
    chk("rd19_valid",  valid_a, 1);
    chk("rd19_pc",     pc_a, 32'h20);
    chk("rd19_instr",  instr_a, 32'h4000_0020);

    stall = 1'b1;
    redirect = 1'b1;
    redirect_pc = 32'h30;
    tick(); // E20: flush despite stall
    redirect = 1'b0;
    stall = 1'b0;
    chk("fs_valid",  valid_a, 0);
    chk("fs_instr",  instr_a, 32'h0);
    chk("fs_opcode", opc_a, 0);
    tick(); // E21: stale response dropped
    chk("e21_req",   req_a, 1);
    chk("e21_addr",  addr_a, 32'h30);
    chk("e21_valid", valid_a, 0);

    ready = 1'b0;
    tick(); // E22
    chk("nr22_req",  req_a, 1);
    chk("nr22_addr", addr_a, 32'h30);
    redirect = 1'b1;
    redirect_pc = 32'h10;
    tick(); // E23
    redirect = 1'b0;
    chk("nr23_req",  req_a, 1);
    chk("nr23_addr", addr_a, 32'h10);
    tick(); // E24
    tick(); // E25
    chk("nr25_rvalid", rvalid_a, 0);
    chk("nr25_addr",   addr_a, 32'h10);
    ready = 1'b1;
    tick(); // E26: only 0x10 accepted
    chk("nr26_acc",    acc_a, 32'h10);
    chk("nr26_rvalid", rvalid_a, 1);
    tick(); // E27
    chk("nr27_valid", valid_a, 1);
    chk("nr27_pc",    pc_a, 32'h10);
    chk("nr27_pc1",   pc1_a, 32'h11);
    chk("nr27_instr", instr_a, 32'h4000_0010);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
